// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 image filter: two line delays build the window, a 3-stage pipeline applies the
// frame-latched kernel, and results queue in an FWFT FIFO with occupancy-based backpressure.
module conv3x3_stream_engine #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_ready,
    input  logic [1:0]        i_mode,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_data_ready,
    output logic              o_intr
);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OW    = AW + 2;
    localparam int ACC_W = DATA_W + 5;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam acc_t          MAXV     = acc_t'((1 << DATA_W) - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    mode_q, mode_d;
    logic          accept, res_in, last_in;

    logic [3:1]    vld_q, last_q;
    logic [3:0]    vld_pipe;

    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [2:0][2:0][DATA_W-1:0] win_q, win_d;

    acc_t        px [3][3];
    acc_t        acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    acc_t        abs_a, abs_b, sob;
    logic [1:0]  md2_q;
    logic [DATA_W-1:0] res_q, res_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    inflight;
    logic          push, pop;

    assign accept  = i_valid & o_data_ready;
    assign res_in  = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign last_in = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign vld_pipe = {vld_q, res_in};
    assign lb0_rd  = lb0_mem[col_q];
    assign lb1_rd  = lb1_mem[col_q];

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        win_d  = win_q;
        if (accept) begin
            if (col_q == '0 && row_q == '0) mode_d = i_mode;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            // newest column: row 0 is two lines back, row 2 is the live pixel
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = i_data;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                px[r][c] = acc_t'({5'b0, win_q[r][c]});
        acc_a_d = '0;
        acc_b_d = '0;
        case (mode_q)
            2'd0: acc_a_d = px[1][1];
            2'd1: acc_a_d = px[0][0] + (px[0][1] <<< 1) + px[0][2]
                          + (px[1][0] <<< 1) + (px[1][1] <<< 2) + (px[1][2] <<< 1)
                          + px[2][0] + (px[2][1] <<< 1) + px[2][2];
            2'd2: begin
                acc_a_d = (px[0][2] + (px[1][2] <<< 1) + px[2][2])
                        - (px[0][0] + (px[1][0] <<< 1) + px[2][0]);
                acc_b_d = (px[2][0] + (px[2][1] <<< 1) + px[2][2])
                        - (px[0][0] + (px[0][1] <<< 1) + px[0][2]);
            end
            default: acc_a_d = (px[1][1] <<< 2) - px[0][1] - px[2][1] - px[1][0] - px[1][2];
        endcase
    end

    always_comb begin
        abs_a = acc_a_q[ACC_W-1] ? -acc_a_q : acc_a_q;
        abs_b = acc_b_q[ACC_W-1] ? -acc_b_q : acc_b_q;
        sob   = abs_a + abs_b;
        case (md2_q)
            2'd0: res_d = acc_a_q[DATA_W-1:0];
            2'd1: res_d = acc_a_q[DATA_W+3:4];
            2'd2: res_d = (sob > MAXV) ? {DATA_W{1'b1}} : sob[DATA_W-1:0];
            default: begin
                if (acc_a_q[ACC_W-1])   res_d = '0;
                else if (acc_a_q > MAXV) res_d = {DATA_W{1'b1}};
                else                     res_d = acc_a_q[DATA_W-1:0];
            end
        endcase
    end

    assign push         = vld_pipe[3];
    assign o_data_valid = (count_q != '0);
    assign pop          = o_data_valid & i_data_ready;
    assign o_data       = o_data_valid ? fifo_mem[rd_ptr_q] : '0;
    assign o_intr       = vld_pipe[3] & last_q[3];
    assign inflight     = {1'b0, vld_q[1]} + {1'b0, vld_q[2]} + {1'b0, vld_q[3]};
    // counting in-flight results keeps a slot reserved for everything already accepted
    assign o_data_ready = (OW'(count_q) + OW'(inflight)) <= OW'(FIFO_DEPTH - 1);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q    <= '0;
            row_q    <= '0;
            mode_q   <= '0;
            vld_q    <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            mode_q   <= mode_d;
            vld_q    <= vld_pipe[2:0];
            last_q   <= {last_q[2:1], last_in};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q   <= win_d;
        acc_a_q <= acc_a_d;
        acc_b_q <= acc_b_d;
        md2_q   <= mode_q;
        res_q   <= res_d;
        if (accept) begin
            lb0_mem[col_q] <= i_data;
            lb1_mem[col_q] <= lb0_rd;
        end
        if (push) fifo_mem[wr_ptr_q] <= res_q;
    end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed + randomized bench for conv3x3_stream_engine; expected pixels come from a direct
// 3x3 convolution of the frame held in the bench.
module tb_conv3x3_stream_engine;
    localparam int DW = 8, W = 8, H = 4, DEPTH = 16, PMAX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_data_ready, o_data_ready, o_data_valid, o_intr;
    logic [DW-1:0] i_data, o_data;
    logic [1:0]    i_mode;

    conv3x3_stream_engine #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_data_ready(o_data_ready),
        .i_mode(i_mode), .o_data_valid(o_data_valid), .o_data(o_data),
        .i_data_ready(i_data_ready), .o_intr(o_intr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int pix [H][W];
    int expq [$];
    int cyc = 0, outst = 0, intr_cnt = 0;
    int cur_r = 0, cur_c = 0;
    int t_first_acc = -1, t_last_acc = -1, t_first_vld = -1, t_intr = -1;
    bit accepted, stall_hold, saw_not_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_px(int m, int r, int c);
        int p [3][3];
        int s, gx, gy;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = pix[r - 1 + i][c - 1 + j];
        case (m)
            0: return p[1][1];
            1: begin
                s = p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
                  + p[2][0] + 2*p[2][1] + p[2][2];
                return s / 16;
            end
            2: begin
                gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
                gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
                s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                return s > PMAX ? PMAX : s;
            end
            default: begin
                s = 4*p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
                return s < 0 ? 0 : (s > PMAX ? PMAX : s);
            end
        endcase
    endfunction

    // one clock: sample outputs at negedge, update the bench's view of the handshakes
    task automatic cycle();
        accepted = 0;
        @(negedge clk);
        cyc++;
        check("ready_vs_occupancy", o_data_ready, (outst <= DEPTH - 1));
        if (!o_data_ready) saw_not_ready = 1;
        if (o_data_valid && t_first_vld < 0) t_first_vld = cyc;
        if (o_data_valid) begin
            if (expq.size() == 0) check("spurious_valid", o_data_valid, 1'b0);
            else begin
                check("o_data_head", o_data, expq[0]);
                if (i_data_ready) begin
                    void'(expq.pop_front());
                    outst--;
                end
            end
        end
        if (o_intr) begin
            intr_cnt++;
            t_intr = cyc;
        end
        if (i_valid && o_data_ready) begin
            accepted = 1;
            if (cur_r >= 2 && cur_c >= 2) outst++;
            if (cur_r == 2 && cur_c == 2) t_first_acc = cyc;
            if (cur_r == H - 1 && cur_c == W - 1) t_last_acc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int rmode);
        case (rmode)
            0: i_data_ready = 1'b1;
            1: i_data_ready = 1'($urandom_range(1));
            default: i_data_ready = stall_hold ? 1'b0 : 1'b1;
        endcase
    endtask

    // pat: 0 ramp, 1 const 200, 2 vertical edge, 3 random; abort_at stops before that pixel
    task automatic send_frame(input int mode, input int pat, input int chg, input bit gaps,
                              input int rmode, input int abort_at);
        int waited;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0: pix[r][c] = r * W + c;
                    1: pix[r][c] = 200;
                    2: pix[r][c] = (c < W / 2) ? 0 : 255;
                    default: pix[r][c] = int'($urandom_range(255));
                endcase
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++)
                expq.push_back(ref_px(mode, r, c));
        i_mode = 2'(mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c == abort_at) return;
                if (chg >= 0 && r == 1 && c == 3) i_mode = 2'(chg);
                cur_r = r;
                cur_c = c;
                i_data = DW'(pix[r][c]);
                if (gaps) begin
                    i_valid = 1'b0;
                    while ($urandom_range(3) == 0) begin
                        set_ready(rmode);
                        cycle();
                    end
                end
                i_valid = 1'b1;
                waited = 0;
                do begin
                    set_ready(rmode);
                    cycle();
                    waited++;
                    if (stall_hold && waited > 10) stall_hold = 0;
                end while (!accepted && waited < 300);
                if (!accepted) begin
                    check("accept_timeout", accepted, 1'b1);
                    i_valid = 1'b0;
                    return;
                end
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic drain(input int exp_intr);
        int n = 0;
        i_valid = 1'b0;
        i_data_ready = 1'b1;
        while (expq.size() > 0 && n < 500) begin
            cycle();
            n++;
        end
        check("drain_empty", expq.size(), 0);
        repeat (6) cycle();
        check("intr_count", intr_cnt, exp_intr);
        intr_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        i_mode = 2'd0;
        i_data_ready = 1'b1;
        #3;
        check("rst_valid", o_data_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_intr", o_intr, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cycle();
        check("rst_ready", o_data_ready, 1'b1);

        // ramp pass-through: latency and interrupt alignment
        t_first_vld = -1;
        send_frame(0, 0, -1, 0, 0, -1);
        drain(1);
        check("first_valid_latency", t_first_vld - t_first_acc, 4);
        check("intr_after_last_accept", t_intr - t_last_acc, 3);

        // constant frame: gaussian keeps it, laplacian zeroes it
        send_frame(1, 1, -1, 0, 0, -1);
        drain(1);
        send_frame(3, 1, -1, 0, 0, -1);
        drain(1);

        // vertical edge through sobel saturates
        send_frame(2, 2, -1, 0, 0, -1);
        drain(1);

        // downstream stalled across two frames until backpressure engages
        stall_hold = 1;
        saw_not_ready = 0;
        i_data_ready = 1'b0;
        send_frame(0, 3, -1, 0, 2, -1);
        send_frame(1, 3, -1, 0, 2, -1);
        check("backpressure_seen", saw_not_ready, 1'b1);
        drain(2);

        // mid-frame mode change is ignored until the next frame
        send_frame(0, 0, 1, 0, 0, -1);
        drain(1);
        send_frame(1, 0, -1, 0, 0, -1);
        drain(1);

        // random data, input gaps and random downstream ready in every mode
        for (int m = 0; m < 4; m++) begin
            send_frame(m, 3, -1, 1, 1, -1);
            drain(1);
        end

        // reset mid-frame at pixel (2,5)
        send_frame(0, 0, -1, 0, 0, 2 * W + 5);
        i_valid = 1'b0;
        rst = 1'b0;
        #2;
        check("abort_valid", o_data_valid, 1'b0);
        check("abort_intr", o_intr, 1'b0);
        check("abort_data", o_data, '0);
        check("abort_no_intr", intr_cnt, 0);
        expq.delete();
        outst = 0;
        intr_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_frame(0, 0, -1, 0, 0, -1);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
